multicycle_controller: RTL and testbench

Control FSM for the multicycle RV32I core variant. It replaces the single-cycle main decoder and sequences one shared ALU and one unified instruction/data memory over several cycles per instruction. It drives every datapath mux select and write enable, and handshakes with memory through `mem_req`/`mem_ready`. It also counts retired instructions and halts on an unsupported opcode.

---
 rtl/multicycle_controller.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_controller                                                      |
// | Sequencing FSM for the multicycle RV32I datapath: mux selects, write       |
// | enables, memory handshake, retired-instruction counter and halt.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALU_Op,
  output logic [1:0]       ImmSrc,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  localparam logic [3:0] c_fetch    = 4'd0;
  localparam logic [3:0] c_decode   = 4'd1;
  localparam logic [3:0] c_memadr   = 4'd2;
  localparam logic [3:0] c_memread  = 4'd3;
  localparam logic [3:0] c_memwb    = 4'd4;
  localparam logic [3:0] c_memwrite = 4'd5;
  localparam logic [3:0] c_execr    = 4'd6;
  localparam logic [3:0] c_execi    = 4'd7;
  localparam logic [3:0] c_aluwb    = 4'd8;
  localparam logic [3:0] c_beq      = 4'd9;
  localparam logic [3:0] c_jal      = 4'd10;
  localparam logic [3:0] c_halt     = 4'd11;

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_itype  = 7'b0010011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;

  logic [3:0]       state_q;
  logic [3:0]       state_d;
  logic [CNT_W-1:0] instret_q;
  logic             w_retire;

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_fetch:    if (mem_ready) state_d = c_decode;
      c_decode: begin
        case (opcode)
          c_op_load, c_op_store: state_d = c_memadr;
          c_op_rtype:            state_d = c_execr;
          c_op_itype:            state_d = c_execi;
          c_op_branch:           state_d = c_beq;
          c_op_jal:              state_d = c_jal;
          default:               state_d = c_halt;
        endcase
      end
      c_memadr:   state_d = (opcode == c_op_store) ? c_memwrite : c_memread;
      c_memread:  if (mem_ready) state_d = c_memwb;
      c_memwb:    state_d = c_fetch;
      c_memwrite: if (mem_ready) state_d = c_fetch;
      c_execr:    state_d = c_aluwb;
      c_execi:    state_d = c_aluwb;
      c_aluwb:    state_d = c_fetch;
      c_beq:      state_d = c_fetch;
      c_jal:      state_d = c_aluwb;
      c_halt:     state_d = c_halt;
      default:    state_d = c_halt;
    endcase
  end

  // An instruction retires on its final transition back into FETCH.
  assign w_retire = (state_q == c_memwb) || (state_q == c_aluwb) ||
                    (state_q == c_beq) || ((state_q == c_memwrite) && mem_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= c_fetch;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (w_retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALU_Op    = 2'b00;
    halted    = 1'b0;
    case (state_q)
      c_fetch: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      c_decode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      c_memadr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      c_memread: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      c_memwb: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      c_memwrite: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      c_execr: begin
        ALUSrcA = 2'b10;
        ALU_Op  = 2'b10;
      end
      c_execi: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALU_Op  = 2'b10;
      end
      c_aluwb:  RegWrite = 1'b1;
      c_beq: begin
        ALUSrcA = 2'b10;
        ALU_Op  = 2'b01;
        PCWrite = zero;
      end
      c_jal: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      c_halt:   halted = 1'b1;
      default: ;
    endcase
    // Reset overrides the FETCH decode so nothing is requested or written.
    if (rst) begin
      mem_req   = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALU_Op    = 2'b00;
      halted    = 1'b0;
    end
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (opcode)
      c_op_store:  ImmSrc = 2'b01;
      c_op_branch: ImmSrc = 2'b10;
      c_op_jal:    ImmSrc = 2'b11;
      default:     ImmSrc = 2'b00;
    endcase
    if (rst) ImmSrc = 2'b00;
  end

  assign instret = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multicycle_controller                                                   |
// | Directed plus randomized instruction streams against a per-instruction     |
// | cycle-sequence reference model.                                            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_multicycle_controller;

  localparam int CNT_W = 4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic             clk = 1'b0;
  logic             rst;
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, halted;
  logic [1:0]       ResultSrc, ALUSrcA, ALUSrcB, ALU_Op, ImmSrc;
  logic [CNT_W-1:0] instret;

  int nchk = 0;
  int nerr = 0;
  int retired = 0;
  logic [6:0] prev_op = 7'd0;

  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALU_Op(ALU_Op), .ImmSrc(ImmSrc),
    .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    if (op == OP_STORE)  return 2'b01;
    if (op == OP_BRANCH) return 2'b10;
    if (op == OP_JAL)    return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    return op == OP_LOAD || op == OP_STORE || op == OP_RTYPE ||
           op == OP_ITYPE || op == OP_BRANCH || op == OP_JAL;
  endfunction

  // Expected control word {mem_req,AdrSrc,MemWrite,IRWrite,PCWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALU_Op,halted}
  function automatic logic [14:0] E(input logic mreq, input logic adr, input logic mw,
                                    input logic irw, input logic pcw, input logic rw,
                                    input logic [1:0] rs, input logic [1:0] a,
                                    input logic [1:0] b, input logic [1:0] alu,
                                    input logic h);
    return {mreq, adr, mw, irw, pcw, rw, rs, a, b, alu, h};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs just after a falling edge, check, move to next falling edge.
  task automatic step(input logic mr, input logic z, input logic [14:0] exp, input string tag);
    mem_ready = mr;
    zero      = z;
    #1;
    chk(tag, {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
              ResultSrc, ALUSrcA, ALUSrcB, ALU_Op, halted}, exp);
    chk({tag, "_imm"}, ImmSrc, rst ? 2'b00 : imm_of(opcode));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    zero = 1'b1;
    #1;
    chk("rst_async_out", {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
                          ResultSrc, ALUSrcA, ALUSrcB, ALU_Op, halted}, 0);
    chk("rst_async_imm", ImmSrc, 0);
    chk("rst_async_instret", instret, 0);
    @(negedge clk);
    #1;
    chk("rst_held_out", {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
                         ResultSrc, ALUSrcA, ALUSrcB, ALU_Op, halted}, 0);
    chk("rst_held_instret", instret, 0);
    rst = 1'b0;
    retired = 0;
  endtask

  task automatic mem_phase(input int waits, input logic [14:0] exp, input string tag);
    for (int i = 0; i < waits; i++) step(1'b0, 1'($urandom), exp, tag);
    step(1'b1, 1'($urandom), exp, tag);
  endtask

  task automatic run_instr(input logic [6:0] op, input int wf, input int wm, input logic zb);
    opcode = prev_op;
    for (int i = 0; i < wf; i++)
      step(1'b0, 1'($urandom), E(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,0), "fetch_wait");
    step(1'b1, 1'($urandom), E(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,0), "fetch");
    opcode = op;
    step(1'($urandom), 1'($urandom), E(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,0), "decode");
    case (op)
      OP_LOAD: begin
        step(1'($urandom), 1'($urandom), E(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0), "memadr");
        mem_phase(wm, E(1,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0), "memread");
        step(1'($urandom), 1'($urandom), E(0,0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,0), "memwb");
        retired++;
      end
      OP_STORE: begin
        step(1'($urandom), 1'($urandom), E(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0), "memadr");
        mem_phase(wm, E(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0), "memwrite");
        retired++;
      end
      OP_RTYPE, OP_ITYPE: begin
        step(1'($urandom), 1'($urandom),
             E(0,0,0,0,0,0,2'b00,2'b10,(op == OP_ITYPE) ? 2'b01 : 2'b00,2'b10,0), "exec");
        step(1'($urandom), 1'($urandom), E(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0), "aluwb");
        retired++;
      end
      OP_BRANCH: begin
        step(1'($urandom), zb, E(0,0,0,0,zb,0,2'b00,2'b10,2'b00,2'b01,0), "beq");
        retired++;
      end
      OP_JAL: begin
        step(1'($urandom), 1'($urandom), E(0,0,0,0,1,0,2'b00,2'b01,2'b10,2'b00,0), "jal");
        step(1'($urandom), 1'($urandom), E(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0), "jal_aluwb");
        retired++;
      end
      default: begin
        for (int i = 0; i < 4; i++)
          step(1'($urandom), 1'($urandom), E(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1), "halt");
        do_reset();
      end
    endcase
    prev_op = op;
    if (is_legal(op)) begin
      #1;
      chk("instret", instret, retired % (1 << CNT_W));
    end
  endtask

  initial begin
    logic [6:0] op;
    int k;
    rst = 1'b1;
    opcode = 7'd0;
    zero = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Load aborted by reset while MEMREAD is still waiting.
    opcode = prev_op;
    step(1'b1, 1'b0, E(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,0), "ab_fetch");
    opcode = OP_LOAD;
    step(1'b0, 1'b0, E(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,0), "ab_decode");
    step(1'b0, 1'b0, E(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0), "ab_memadr");
    step(1'b0, 1'b0, E(1,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0), "ab_memread");
    do_reset();
    prev_op = OP_LOAD;
    step(1'b0, 1'b0, E(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,0), "ab_refetch");
    opcode = prev_op;

    // Directed: add, lw, sw with 3 waits, beq taken/not, jal, illegal.
    run_instr(OP_RTYPE, 0, 0, 1'b0);
    run_instr(OP_LOAD, 0, 0, 1'b0);
    run_instr(OP_STORE, 0, 3, 1'b0);
    run_instr(OP_BRANCH, 0, 0, 1'b1);
    run_instr(OP_BRANCH, 0, 0, 1'b0);
    run_instr(OP_JAL, 0, 0, 1'b0);
    run_instr(7'b0000000, 0, 0, 1'b0);

    for (int n = 0; n < 250; n++) begin
      k = $urandom_range(0, 12);
      case (k / 2)
        0: op = OP_LOAD;
        1: op = OP_STORE;
        2: op = OP_RTYPE;
        3: op = OP_ITYPE;
        4: op = OP_BRANCH;
        5: op = OP_JAL;
        default: begin
          op = 7'($urandom);
          while (is_legal(op)) op = 7'($urandom);
        end
      endcase
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
